debounced_event_counter: RTL and testbench

Parametrised next generation of the push-button counter path: synchronises a raw mechanical input, debounces it with a configurable stability window, and counts debounced presses. Adds up/down mode, wrap or saturate policy, synchronous clear, and a sticky limit flag. Sits between a board button and the display/LED driver that consumes the count.

---
 rtl/debounced_event_counter.sv | 127 ++++++++++++
 tb/tb_debounced_event_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/debounced_event_counter.sv
// Push-button event counter: two-flop synchroniser, stability-window debouncer,
// and an up/down press counter with wrap or saturate policy and a sticky limit flag.
module debounced_event_counter #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          SATURATE        = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             mode_down,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             pressed,
  output logic             pulse,
  output logic             limit_hit
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX_CNT  = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic            sync_d;
  logic            sync_q;
  logic [CW-1:0]   stab_cnt;

  // Synchroniser and debounce FSM; the current sample counts toward the window,
  // so a transition fires when the counter already holds DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d   <= 1'b0;
      sync_q   <= 1'b0;
      stab_cnt <= '0;
      state    <= IDLE;
      pressed  <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync_d <= trigger;
      sync_q <= sync_d;
      pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q) begin
            state    <= WAIT_PRESS;
            stab_cnt <= CW'(1);
          end else begin
            stab_cnt <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync_q) begin
            state    <= IDLE;
            stab_cnt <= '0;
          end else if (stab_cnt == LAST_CNT) begin
            state    <= PRESSED;
            pressed  <= 1'b1;
            pulse    <= 1'b1;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync_q) begin
            state    <= WAIT_RELEASE;
            stab_cnt <= CW'(1);
          end else begin
            stab_cnt <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync_q) begin
            state    <= PRESSED;
            stab_cnt <= '0;
          end else if (stab_cnt == LAST_CNT) begin
            state    <= IDLE;
            pressed  <= 1'b0;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          pressed  <= 1'b0;
          stab_cnt <= '0;
        end
      endcase
    end
  end

  // Press counter; clear discards any update landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      limit_hit <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      limit_hit <= 1'b0;
    end else if (pulse) begin
      if (mode_down) begin
        if (count == '0) begin
          limit_hit <= 1'b1;
          if (!SATURATE) count <= MAX_CNT;
        end else begin
          count <= count - WIDTH'(1);
        end
      end else begin
        if (count == MAX_CNT) begin
          limit_hit <= 1'b1;
          if (!SATURATE) count <= '0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debounced_event_counter.sv
// Directed bench: a wrapping and a saturating instance share all inputs.
module tb_debounced_event_counter;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst, trigger, mode_down, clear;
  logic [W-1:0] count0, count1;
  logic         pressed0, pressed1, pulse0, pulse1, limit0, limit1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  int n_pressed_seen = 0;

  always #5 clk = ~clk;

  debounced_event_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .trigger(trigger), .mode_down(mode_down), .clear(clear),
    .count(count0), .pressed(pressed0), .pulse(pulse0), .limit_hit(limit0)
  );

  debounced_event_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .trigger(trigger), .mode_down(mode_down), .clear(clear),
    .count(count1), .pressed(pressed1), .pulse(pulse1), .limit_hit(limit1)
  );

  always @(negedge clk) begin
    if (pulse0) n_pulse++;
    if (pressed0) n_pressed_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold);
    trigger = 1'b1;
    tick(hold);
    trigger = 1'b0;
    tick(hold);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; mode_down = 1'b0; clear = 1'b0;
    tick(3);
    check("rst_count", 32'(count0), 0);
    check("rst_pressed", 32'(pressed0), 0);
    check("rst_pulse", 32'(pulse0), 0);
    check("rst_limit", 32'(limit0), 0);
    rst = 1'b0;
    tick(2);

    // Bounce: 2-cycle toggles never fill a 4-sample window
    n_pulse = 0; n_pressed_seen = 0;
    for (int i = 0; i < 8; i++) begin
      trigger = ~trigger;
      tick(2);
    end
    trigger = 1'b0;
    tick(10);
    check("bounce_pulses", 32'(n_pulse), 0);
    check("bounce_pressed", 32'(n_pressed_seen), 0);
    check("bounce_count", 32'(count0), 0);

    // Clean press: pulse at edge k+5, count one edge later
    n_pulse = 0;
    trigger = 1'b1;
    tick(5);
    check("press_k4_pressed", 32'(pressed0), 0);
    tick();
    check("press_k5_pressed", 32'(pressed0), 1);
    check("press_k5_pulse", 32'(pulse0), 1);
    check("press_k5_count", 32'(count0), 0);
    tick();
    check("press_k6_pulse", 32'(pulse0), 0);
    check("press_k6_count", 32'(count0), 1);
    check("press_k6_count_sat", 32'(count1), 1);
    tick(13);
    trigger = 1'b0;
    tick(5);
    check("release_r4_pressed", 32'(pressed0), 1);
    tick();
    check("release_r5_pressed", 32'(pressed0), 0);
    tick(14);
    check("press_pulses", 32'(n_pulse), 1);
    check("press_limit", 32'(limit0), 0);

    // Wrap vs saturate over 16 up presses
    do_clear();
    for (int i = 0; i < 15; i++) press(10);
    check("up15_wrap", 32'(count0), 15);
    check("up15_sat", 32'(count1), 15);
    check("up15_limit", 32'(limit0), 0);
    press(10);
    check("up16_wrap", 32'(count0), 0);
    check("up16_sat", 32'(count1), 15);
    check("up16_limit_wrap", 32'(limit0), 1);
    check("up16_limit_sat", 32'(limit1), 1);

    // Down from zero
    do_clear();
    check("clr_limit", 32'(limit0), 0);
    mode_down = 1'b1;
    press(10);
    check("down_wrap", 32'(count0), 15);
    check("down_sat", 32'(count1), 0);
    check("down_limit_wrap", 32'(limit0), 1);
    check("down_limit_sat", 32'(limit1), 1);
    press(10);
    check("down_again_wrap", 32'(count0), 14);
    mode_down = 1'b0;

    // Clear coinciding with the 5 -> 6 update
    do_clear();
    for (int i = 0; i < 5; i++) press(10);
    check("pre_clr_count", 32'(count0), 5);
    trigger = 1'b1;
    tick(6);
    check("coll_pulse", 32'(pulse0), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("coll_count", 32'(count0), 0);
    check("coll_limit", 32'(limit0), 0);
    tick(5);
    trigger = 1'b0;
    tick(10);
    check("coll_hold_count", 32'(count0), 0);
    press(10);
    check("after_coll_count", 32'(count0), 1);

    // Reset inside the press window with the button still held
    n_pulse = 0;
    trigger = 1'b1;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", 32'(count0), 0);
    check("midrst_pressed", 32'(pressed0), 0);
    check("midrst_pulse", 32'(pulse0), 0);
    tick(5);
    check("midrst_m4_pressed", 32'(pressed0), 0);
    tick();
    check("midrst_m5_pulse", 32'(pulse0), 1);
    tick();
    check("midrst_m6_count", 32'(count0), 1);
    check("midrst_m6_count_sat", 32'(count1), 1);
    tick(5);
    trigger = 1'b0;
    tick(10);
    check("midrst_pulses", 32'(n_pulse), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
